// File: rtl/dual_rate_counter.sv
`timescale 1ns/1ps
// ============================================================================
// dual_rate_counter
// ----------------------------------------------------------------------------
// Two-stage counter for the lab timing/sequence blocks.
//
//   * Prescaler (lo_count, LO_W bits) counts 0,1,2,... and returns to 0 on
//     the edge after it equals `terminal` (that compare is the "tick").
//   * Accumulator (hi_count, HI_W bits) either adds `step` on every enabled
//     cycle (fast_mode=1) or adds 1 on each prescaler tick (fast_mode=0).
//   * The accumulator's carry out is registered into wrap_pulse, a one-cycle
//     event pulse for downstream counters.
//
// Parameters:
//   LO_W        prescaler width in bits (>= 2)
//   HI_W        accumulator width in bits (>= 2)
//
// Ports:
//   clk         rising-edge system clock
//   clear_n     asynchronous active-low reset (all state to 0)
//   sync_clear  synchronous clear, active high, highest priority at an edge
//   enable      count enable; 0 holds both counters and drops wrap_pulse
//   fast_mode   1: accumulator += step each enabled cycle; 0: += 1 per tick
//   step        fast-mode increment, unsigned
//   terminal    prescaler terminal value, unsigned
//   cct_output  {hi_count, lo_count}, straight from the registers
//   wrap_pulse  high for one cycle after an edge whose accumulator add carried
//
// Build option:
//   DUAL_RATE_COUNTER_SATURATE_EN  when defined, the first accumulator
//   overflow loads all-ones into hi_count and freezes it there until
//   sync_clear or clear_n; wrap_pulse fires only for that first overflow.
//   When undefined, hi_count wraps modulo 2^HI_W.
// ============================================================================
module dual_rate_counter #(
    parameter int LO_W = 4,
    parameter int HI_W = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 sync_clear,
    input  logic                 enable,
    input  logic                 fast_mode,
    input  logic [HI_W-1:0]      step,
    input  logic [LO_W-1:0]      terminal,
    output logic [HI_W+LO_W-1:0] cct_output,
    output logic                 wrap_pulse
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [LO_W-1:0] lo_count;
    logic [HI_W-1:0] hi_count;

`ifdef DUAL_RATE_COUNTER_SATURATE_EN
    // Set by the first overflow; freezes hi_count and masks further pulses.
    logic            sat_hold;
    logic            sat_hold_next;
`endif

    // ------------------------------------------------------------------------
    // Next-state datapath (only applied when enabled and not cleared)
    // ------------------------------------------------------------------------
    logic            tick;
    logic [LO_W-1:0] lo_next;
    logic            hi_add_en;
    logic [HI_W-1:0] hi_inc;
    logic [HI_W:0]   hi_sum;
    logic            hi_carry;
    logic [HI_W-1:0] hi_next;
    logic            wrap_next;

    // Prescaler: exact equality only. If terminal is lowered below lo_count
    // the prescaler simply runs on through its natural wrap to reach it.
    always_comb begin
        tick    = (lo_count == terminal);
        lo_next = tick ? '0 : lo_count + 1'b1;
    end

    // Accumulator add is one bit wider than hi_count so the carry is explicit.
    always_comb begin
        hi_add_en = fast_mode | tick;
        hi_inc    = fast_mode ? step : {{(HI_W-1){1'b0}}, 1'b1};
        hi_sum    = {1'b0, hi_count} + {1'b0, hi_inc};
        hi_carry  = hi_add_en & hi_sum[HI_W];
    end

`ifdef DUAL_RATE_COUNTER_SATURATE_EN
    always_comb begin
        hi_next       = hi_count;
        wrap_next     = 1'b0;
        sat_hold_next = sat_hold;
        if (sat_hold) begin
            // Frozen at all-ones: ignore further adds and their carries.
            hi_next   = hi_count;
            wrap_next = 1'b0;
        end else if (hi_carry) begin
            hi_next       = '1;
            wrap_next     = 1'b1;
            sat_hold_next = 1'b1;
        end else if (hi_add_en) begin
            hi_next = hi_sum[HI_W-1:0];
        end
    end
`else
    always_comb begin
        hi_next   = hi_add_en ? hi_sum[HI_W-1:0] : hi_count;
        wrap_next = hi_carry;
    end
`endif

    // ------------------------------------------------------------------------
    // Registers: async reset, then sync_clear > enable > count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            lo_count   <= '0;
            hi_count   <= '0;
            wrap_pulse <= 1'b0;
        end else if (sync_clear) begin
            lo_count   <= '0;
            hi_count   <= '0;
            wrap_pulse <= 1'b0;
        end else if (!enable) begin
            wrap_pulse <= 1'b0;
        end else begin
            lo_count   <= lo_next;
            hi_count   <= hi_next;
            wrap_pulse <= wrap_next;
        end
    end

`ifdef DUAL_RATE_COUNTER_SATURATE_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sat_hold <= 1'b0;
        end else if (sync_clear) begin
            sat_hold <= 1'b0;
        end else if (enable) begin
            sat_hold <= sat_hold_next;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Status word: no extra register stage
    // ------------------------------------------------------------------------
    assign cct_output = {hi_count, lo_count};

endmodule

// File: tb/tb_dual_rate_counter.sv
`timescale 1ns/1ps
module tb_dual_rate_counter;

    localparam int LO_W = 4;
    localparam int HI_W = 4;
    localparam int LO_MOD = 1 << LO_W;
    localparam int HI_MOD = 1 << HI_W;

    logic                 clk;
    logic                 clear_n;
    logic                 sync_clear;
    logic                 enable;
    logic                 fast_mode;
    logic [HI_W-1:0]      step;
    logic [LO_W-1:0]      terminal;
    logic [HI_W+LO_W-1:0] cct_output;
    logic                 wrap_pulse;

    dual_rate_counter #(.LO_W(LO_W), .HI_W(HI_W)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .sync_clear (sync_clear),
        .enable     (enable),
        .fast_mode  (fast_mode),
        .step       (step),
        .terminal   (terminal),
        .cct_output (cct_output),
        .wrap_pulse (wrap_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers, counters as numbers modulo 2^W.
    int unsigned m_lo   = 0;
    int unsigned m_hi   = 0;
    bit          m_wrap = 1'b0;
    bit          m_sat  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lo = 0; m_hi = 0; m_wrap = 1'b0; m_sat = 1'b0;
    endtask

    task automatic model_edge();
        bit          t;
        int unsigned add;
        int unsigned total;
        if (sync_clear) begin
            model_reset();
        end else if (!enable) begin
            m_wrap = 1'b0;
        end else begin
            t     = (m_lo == int'(terminal));
            add   = fast_mode ? int'(step) : (t ? 1 : 0);
            m_lo  = t ? 0 : (m_lo + 1) % LO_MOD;
            total = m_hi + add;
`ifdef DUAL_RATE_COUNTER_SATURATE_EN
            if (m_sat) begin
                m_wrap = 1'b0;
            end else if (total >= HI_MOD) begin
                m_hi = HI_MOD - 1; m_sat = 1'b1; m_wrap = 1'b1;
            end else begin
                m_hi = total; m_wrap = 1'b0;
            end
`else
            m_hi   = total % HI_MOD;
            m_wrap = (total >= HI_MOD);
`endif
        end
    endtask

    function automatic logic [31:0] exp_cct();
        return 32'((m_hi << LO_W) | m_lo);
    endfunction

    // One active edge: update the model from the inputs the DUT sampled,
    // then compare just after the edge.
    task automatic run_edge(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "/cct"},  32'(cct_output), exp_cct());
        chk({tag, "/wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    endtask

    task automatic do_sync_clear();
        sync_clear = 1'b1; enable = 1'b1;
        run_edge("sclr");
        sync_clear = 1'b0;
    endtask

    int unsigned hi_seq [6];
    logic [31:0] held;

    initial begin
        hi_seq = '{3, 6, 9, 12, 15, 2};
        clear_n = 1'b0; sync_clear = 1'b0; enable = 1'b0; fast_mode = 1'b0;
        step = '0; terminal = '0;
        #2;
        chk("reset/cct",  32'(cct_output), 32'h0);
        chk("reset/wrap", 32'(wrap_pulse), 32'h0);
        clear_n = 1'b1;
        model_reset();

        // Slow mode, terminal 7, 16 edges from clear -> 8'h20.
        terminal = 4'd7; fast_mode = 1'b0; enable = 1'b1;
        for (int i = 0; i < 16; i++) run_edge("slow7");
        chk("slow7/final", 32'(cct_output), 32'h20);

        // Fast mode, step 3: 3,6,9,12,15 then overflow.
        do_sync_clear();
        terminal = 4'd15; fast_mode = 1'b1; step = 4'd3;
        for (int i = 0; i < 6; i++) begin
            run_edge("fast3");
`ifdef DUAL_RATE_COUNTER_SATURATE_EN
            chk("fast3/hi", 32'(cct_output[7:4]), (i == 5) ? 32'd15 : hi_seq[i]);
`else
            chk("fast3/hi", 32'(cct_output[7:4]), hi_seq[i]);
`endif
            chk("fast3/pulse", 32'(wrap_pulse), (i == 5) ? 32'd1 : 32'd0);
        end
        run_edge("fast3_after");
        chk("fast3_after/pulse", 32'(wrap_pulse), 32'd0);

        // Terminal 0: tick every cycle, hi counts each edge, overflow on 16th.
        do_sync_clear();
        terminal = 4'd0; fast_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            run_edge("term0");
            chk("term0/lo", 32'(cct_output[3:0]), 32'd0);
        end
        chk("term0/pulse16", 32'(wrap_pulse), 32'd1);

        // Terminal lowered below lo: runs through the wrap to reach it.
        do_sync_clear();
        terminal = 4'd15;
        for (int i = 0; i < 5; i++) run_edge("lower_pre");
        terminal = 4'd2;
        for (int i = 0; i < 13; i++) run_edge("lower_run");
        chk("lower/at2", 32'(cct_output), 32'h02);
        run_edge("lower_tick");
        chk("lower/ticked", 32'(cct_output), 32'h10);

        // Hold for 3 cycles, then sync_clear together with enable.
        terminal = 4'd7;
        run_edge("pre_hold");
        held = 32'(cct_output);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_edge("hold");
            chk("hold/value", 32'(cct_output), held);
        end
        do_sync_clear();
        chk("sclr/cct", 32'(cct_output), 32'h0);
        chk("sclr/wrap", 32'(wrap_pulse), 32'h0);

        // Reach hi=9, lo=4, then async clear between edges.
        terminal = 4'd15; fast_mode = 1'b1; step = 4'd9;
        run_edge("to94_a");
        fast_mode = 1'b0;
        for (int i = 0; i < 3; i++) run_edge("to94_b");
        chk("to94/value", 32'(cct_output), 32'h94);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        chk("async/cct", 32'(cct_output), 32'h0);
        chk("async/wrap", 32'(wrap_pulse), 32'h0);
        clear_n = 1'b1;
        run_edge("resume");
        chk("resume/value", 32'(cct_output), 32'h01);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            sync_clear = ($urandom_range(0, 24) == 0);
            enable     = ($urandom_range(0, 5) != 0);
            fast_mode  = ($urandom_range(0, 2) == 0);
            step       = HI_W'($urandom);
            if ($urandom_range(0, 7) == 0) terminal = LO_W'($urandom);
            run_edge("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                clear_n = 1'b0;
                #1;
                model_reset();
                chk("rand_async/cct", 32'(cct_output), 32'h0);
                chk("rand_async/wrap", 32'(wrap_pulse), 32'h0);
                clear_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
